// File: rtl/global_defs.sv
// Shared types and defaults for the memory-side arbiter slice.
// Cache and DRAM request/response field types live here.
package global_defs;

  localparam int ADDR_W_DEF = 29;
  localparam int DATA_W_DEF = 64;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef logic [ADDR_W_DEF-1:0] main_mem_block_addr_t;
  typedef logic [DATA_W_DEF-1:0] block_data_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } mem_owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Two-way grant: icache wins unless dcache has been passed over
// STARVE_LIMIT times in a row, then dcache is forced through.
module mem_arb_prio
  import global_defs::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_aL,
  input  logic i_en,
  input  logic i_icache_valid,
  input  logic i_dcache_valid,
  output logic o_icache_grant,
  output logic o_dcache_grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;
  logic       w_starved;

  assign w_starved = (r_cnt == LIMIT);

  assign o_dcache_grant = i_en & i_dcache_valid
                        & (~i_icache_valid | w_starved);
  assign o_icache_grant = i_en & i_icache_valid
                        & ~o_dcache_grant;

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      r_cnt <= '0;
    end else if (o_dcache_grant) begin
      r_cnt <= '0;
    end else if (o_icache_grant && i_dcache_valid
                 && !w_starved) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates icache/dcache block requests onto one DRAM port,
// one transaction in flight, response routed back as a pulse.
module mem_ctrl_arbiter
  import global_defs::*;
#(
  parameter int BLOCK_ADDR_WIDTH = ADDR_W_DEF,
  parameter int BLOCK_DATA_WIDTH = DATA_W_DEF,
  parameter int STARVE_LIMIT     = STARVE_LIMIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic                        icache_req_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
  input  logic                        dcache_req_valid,
  input  req_type_t                   dcache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data,
  output logic                        dram_req_valid,
  output req_type_t                   dram_req_type,
  output logic [BLOCK_ADDR_WIDTH-1:0] dram_req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] dram_req_block_data,
  input  logic                        dram_req_ready,
  input  logic                        dram_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] dram_resp_block_data
);

  mem_ctrl_state_t             r_state;
  mem_ctrl_state_t             w_next;
  mem_owner_t                  r_owner;
  req_type_t                   r_type;
  logic [BLOCK_ADDR_WIDTH-1:0] r_addr;
  logic [BLOCK_DATA_WIDTH-1:0] r_wdata;
  logic [BLOCK_DATA_WIDTH-1:0] r_iresp_data;
  logic [BLOCK_DATA_WIDTH-1:0] r_dresp_data;
  logic                        w_idle;
  logic                        w_igrant;
  logic                        w_dgrant;
  logic                        w_resp_in;

  // Readies stay low while reset is being applied.
  assign w_idle = (r_state == IDLE) & rst_aL;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk           (clk),
    .rst_aL        (rst_aL),
    .i_en          (w_idle),
    .i_icache_valid(icache_req_valid),
    .i_dcache_valid(dcache_req_valid),
    .o_icache_grant(w_igrant),
    .o_dcache_grant(w_dgrant)
  );

  assign icache_req_ready       = w_igrant;
  assign dcache_req_ready       = w_dgrant;
  assign dram_req_type          = r_type;
  assign dram_req_block_addr    = r_addr;
  assign dram_req_block_data    = r_wdata;
  assign icache_resp_block_data = r_iresp_data;
  assign dcache_resp_block_data = r_dresp_data;
  assign w_resp_in = (r_state == WAIT) & dram_resp_valid;

  always_comb begin
    w_next            = r_state;
    dram_req_valid    = 1'b0;
    icache_resp_valid = 1'b0;
    dcache_resp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_igrant || w_dgrant) w_next = ISSUE;
      end
      ISSUE: begin
        dram_req_valid = 1'b1;
        if (dram_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (dram_resp_valid) w_next = RESP;
      end
      RESP: begin
        icache_resp_valid = (r_owner == ICACHE);
        dcache_resp_valid = (r_owner == DCACHE);
        w_next            = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      r_state      <= IDLE;
      r_owner      <= ICACHE;
      r_type       <= READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_iresp_data <= '0;
      r_dresp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_igrant) begin
        r_owner <= ICACHE;
        r_type  <= READ;
        r_addr  <= icache_req_block_addr;
        r_wdata <= '0;
      end else if (w_dgrant) begin
        r_owner <= DCACHE;
        r_type  <= dcache_req_type;
        r_addr  <= dcache_req_block_addr;
        r_wdata <= dcache_req_block_data;
      end
      // Write completions return an all-zero block.
      if (w_resp_in) begin
        if (r_owner == ICACHE) begin
          r_iresp_data <= dram_resp_block_data;
        end else if (r_type == WRITE) begin
          r_dresp_data <= '0;
        end else begin
          r_dresp_data <= dram_resp_block_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Randomized + directed bench for mem_ctrl_arbiter with a
// memory-level reference model and response scoreboard.
module tb_mem_ctrl_arbiter;
  import global_defs::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        icache_req_valid;
  logic [28:0] icache_req_block_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [63:0] icache_resp_block_data;
  logic        dcache_req_valid;
  req_type_t   dcache_req_type;
  logic [28:0] dcache_req_block_addr;
  logic [63:0] dcache_req_block_data;
  logic        dcache_req_ready;
  logic        dcache_resp_valid;
  logic [63:0] dcache_resp_block_data;
  logic        dram_req_valid;
  req_type_t   dram_req_type;
  logic [28:0] dram_req_block_addr;
  logic [63:0] dram_req_block_data;
  logic        dram_req_ready;
  logic        dram_resp_valid;
  logic [63:0] dram_resp_block_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_arbiter #(
    .BLOCK_ADDR_WIDTH(29),
    .BLOCK_DATA_WIDTH(64),
    .STARVE_LIMIT    (LIM)
  ) dut (
    .clk                   (clk),
    .rst_aL                (rst_aL),
    .icache_req_valid      (icache_req_valid),
    .icache_req_block_addr (icache_req_block_addr),
    .icache_req_ready      (icache_req_ready),
    .icache_resp_valid     (icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid      (dcache_req_valid),
    .dcache_req_type       (dcache_req_type),
    .dcache_req_block_addr (dcache_req_block_addr),
    .dcache_req_block_data (dcache_req_block_data),
    .dcache_req_ready      (dcache_req_ready),
    .dcache_resp_valid     (dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data),
    .dram_req_valid        (dram_req_valid),
    .dram_req_type         (dram_req_type),
    .dram_req_block_addr   (dram_req_block_addr),
    .dram_req_block_data   (dram_req_block_data),
    .dram_req_ready        (dram_req_ready),
    .dram_resp_valid       (dram_resp_valid),
    .dram_resp_block_data  (dram_resp_block_data)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h t=%0t",
                  nm, act, exp, $time);
  endtask

  function automatic logic [63:0] dflt(input logic [28:0] a);
    return {a ^ 29'h0A5A5A5A, 3'b101, ~a, 3'b011};
  endfunction

  // Reference memory (scoreboard side) and DRAM responder memory.
  logic [63:0] ref_mem  [logic [28:0]];
  logic [63:0] dram_mem [logic [28:0]];

  function automatic logic [63:0] ref_rd(input logic [28:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // ---------------- DRAM responder ----------------
  int dram_lat   = 3;
  bit lat_rand   = 0;
  int bp_cycles  = 0;
  bit bp_rand    = 0;
  int spur_cnt   = 0;

  initial begin
    int waited, cnt, spur_last, bp_r;
    bit pend, hs, stall;
    logic [63:0] rdata, d;
    logic [28:0] a;
    req_type_t t;
    waited = 0; cnt = 0; spur_last = 0; bp_r = 0;
    pend = 0; rdata = '0;
    dram_req_ready       = 1'b1;
    dram_resp_valid      = 1'b0;
    dram_resp_block_data = '0;
    forever begin
      @(negedge clk);
      hs    = dram_req_valid && dram_req_ready;
      stall = dram_req_valid && !dram_req_ready;
      t = dram_req_type;
      a = dram_req_block_addr;
      d = dram_req_block_data;
      @(posedge clk); #1;
      dram_resp_valid = 1'b0;
      if (hs) begin
        waited = 0;
        bp_r   = $urandom_range(0, 2);
        if (t == WRITE) begin
          dram_mem[a] = d;
          rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
          rdata = dram_mem.exists(a) ? dram_mem[a] : dflt(a);
        end
        cnt  = lat_rand ? $urandom_range(1, 6) : dram_lat;
        pend = 1;
      end else if (stall) begin
        waited++;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          dram_resp_valid      = 1'b1;
          dram_resp_block_data = rdata;
          pend = 0;
        end
      end else if (spur_cnt != spur_last) begin
        spur_last            = spur_cnt;
        dram_resp_valid      = 1'b1;
        dram_resp_block_data = 64'h5555_AAAA_5555_AAAA;
      end
      dram_req_ready = (waited >= (bp_rand ? bp_r : bp_cycles));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    mem_owner_t  own;
    logic [63:0] data;
  } exp_t;
  typedef struct {
    req_type_t   t;
    logic [28:0] a;
    logic [63:0] d;
  } dreq_t;

  exp_t       expq[$];
  dreq_t      dq[$];
  mem_owner_t glog[$];
  int mcnt = 0;
  int last_grant = -100;
  int grant_cyc = 0;
  int resp_cyc = 0;
  int dvalid_cyc = 0;
  int n_resp = 0;
  int stall_n = 0;
  int dram_hs_cnt = 0;
  logic [63:0] last_i = '0;
  logic [63:0] last_d = '0;

  initial begin
    bit ig, dg, exp_dg, prev_resp, prev_stall, prev_dv, iv, dv;
    dreq_t cur, prev_f, e;
    exp_t  x;
    prev_resp = 0; prev_stall = 0; prev_dv = 0;
    forever begin
      @(negedge clk);
      if (!rst_aL) begin
        expq.delete();
        dq.delete();
        mcnt = 0; last_grant = -100;
        prev_resp = 0; prev_stall = 0; prev_dv = 0;
        last_i = '0; last_d = '0;
      end else begin
        ig = icache_req_valid && icache_req_ready;
        dg = dcache_req_valid && dcache_req_ready;
        if (ig || dg) begin
          exp_dg = dcache_req_valid
                   && (!icache_req_valid || mcnt == LIM);
          chk(!(ig && dg) && dg == exp_dg, "grant_owner",
              64'({ig, dg}), 64'({!exp_dg, exp_dg}));
          chk(cyc - last_grant >= 4, "grant_spacing",
              64'(cyc - last_grant), 64'd4);
          last_grant = cyc;
          grant_cyc  = cyc;
          stall_n    = 0;
          if (dg) mcnt = 0;
          else if (dcache_req_valid && mcnt < LIM) mcnt++;
          glog.push_back(dg ? DCACHE : ICACHE);
          if (dg) begin
            e.t = dcache_req_type;
            e.a = dcache_req_block_addr;
            e.d = dcache_req_block_data;
            x.own = DCACHE;
            if (e.t == WRITE) begin
              x.data = '0;
              ref_mem[e.a] = e.d;
            end else begin
              x.data = ref_rd(e.a);
            end
          end else begin
            e.t = READ;
            e.a = icache_req_block_addr;
            e.d = '0;
            x.own  = ICACHE;
            x.data = ref_rd(e.a);
          end
          dq.push_back(e);
          expq.push_back(x);
        end
        if (dram_req_valid) begin
          cur.t = dram_req_type;
          cur.a = dram_req_block_addr;
          cur.d = dram_req_block_data;
          if (!prev_dv) dvalid_cyc = cyc;
          chk(!icache_req_ready && !dcache_req_ready,
              "ready_busy",
              64'({icache_req_ready, dcache_req_ready}), 64'd0);
          if (prev_stall)
            chk(cur.a == prev_f.a && cur.d == prev_f.d
                && cur.t == prev_f.t, "dram_hold",
                64'(cur.a), 64'(prev_f.a));
          if (dram_req_ready) begin
            dram_hs_cnt++;
            prev_stall = 0;
            if (dq.size() == 0) begin
              chk(0, "dram_req_unexpected", 64'(cur.a), 64'd0);
            end else begin
              e = dq.pop_front();
              chk(cur.t == e.t, "dram_type",
                  64'(cur.t), 64'(e.t));
              chk(cur.a == e.a, "dram_addr",
                  64'(cur.a), 64'(e.a));
              chk(cur.d == e.d, "dram_data", cur.d, e.d);
            end
          end else begin
            stall_n++;
            prev_stall = 1;
            prev_f     = cur;
          end
        end else begin
          prev_stall = 0;
        end
        prev_dv = dram_req_valid;
        iv = icache_resp_valid;
        dv = dcache_resp_valid;
        if (iv || dv) begin
          n_resp++;
          resp_cyc = cyc;
          chk(!(iv && dv), "resp_onehot", 64'({iv, dv}), 64'd1);
          chk(!prev_resp, "resp_width", 64'd2, 64'd1);
          if (expq.size() == 0) begin
            chk(0, "resp_unexpected", 64'({iv, dv}), 64'd0);
          end else begin
            x = expq.pop_front();
            chk((iv ? ICACHE : DCACHE) == x.own, "resp_owner",
                64'(dv), 64'(x.own));
            chk((iv ? icache_resp_block_data
                    : dcache_resp_block_data) == x.data,
                "resp_data",
                iv ? icache_resp_block_data
                   : dcache_resp_block_data, x.data);
            if (iv) last_i = x.data;
            else    last_d = x.data;
          end
        end
        if (!iv)
          chk(icache_resp_block_data == last_i, "i_data_hold",
              icache_resp_block_data, last_i);
        if (!dv)
          chk(dcache_resp_block_data == last_d, "d_data_hold",
              dcache_resp_block_data, last_d);
        prev_resp = iv || dv;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_outs_zero(input string nm);
    logic [63:0] any;
    any = icache_resp_block_data | dcache_resp_block_data
        | dram_req_block_data | 64'(dram_req_block_addr)
        | 64'({icache_req_ready, icache_resp_valid,
               dcache_req_ready, dcache_resp_valid,
               dram_req_valid, dram_req_type});
    chk(any == '0, nm, any, 64'd0);
  endtask

  task automatic req_i(input logic [28:0] a);
    bit g;
    g = 0;
    icache_req_valid      = 1'b1;
    icache_req_block_addr = a;
    for (int k = 0; k < 60 && !g; k++) begin
      @(negedge clk);
      g = icache_req_ready;
      step();
    end
    icache_req_valid = 1'b0;
    chk(g, "i_grant", 64'(g), 64'd1);
  endtask

  task automatic req_d(input req_type_t t, input logic [28:0] a,
                       input logic [63:0] d);
    bit g;
    g = 0;
    dcache_req_valid      = 1'b1;
    dcache_req_type       = t;
    dcache_req_block_addr = a;
    dcache_req_block_data = d;
    for (int k = 0; k < 60 && !g; k++) begin
      @(negedge clk);
      g = dcache_req_ready;
      step();
    end
    dcache_req_valid = 1'b0;
    chk(g, "d_grant", 64'(g), 64'd1);
  endtask

  task automatic wait_resp(input int r0);
    for (int k = 0; k < 100 && n_resp <= r0; k++) step();
    chk(n_resp > r0, "resp_timeout", 64'(n_resp), 64'(r0 + 1));
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (expq.size() != 0
         || dram_req_valid); k++) step();
    step();
    chk(expq.size() == 0, "drain", 64'(expq.size()), 64'd0);
  endtask

  // Keep any still-pending request valid until it is granted.
  task automatic hold_until_granted();
    bit ig, dg;
    for (int k = 0; k < 200 && (icache_req_valid
         || dcache_req_valid); k++) begin
      @(negedge clk);
      ig = icache_req_valid && icache_req_ready;
      dg = dcache_req_valid && dcache_req_ready;
      step();
      if (ig) icache_req_valid = 1'b0;
      if (dg) dcache_req_valid = 1'b0;
    end
    chk(!icache_req_valid && !dcache_req_valid, "hold_grant",
        64'({icache_req_valid, dcache_req_valid}), 64'd0);
  endtask

  mem_owner_t exp_seq[10] = '{ICACHE, ICACHE, ICACHE, ICACHE,
                              DCACHE, ICACHE, ICACHE, ICACHE,
                              ICACHE, DCACHE};

  initial begin
    int r0, h0;
    bit ig, dg, ok;
    rst_aL                = 1'b0;
    icache_req_valid      = 1'b0;
    icache_req_block_addr = '0;
    dcache_req_valid      = 1'b0;
    dcache_req_type       = READ;
    dcache_req_block_addr = '0;
    dcache_req_block_data = '0;
    ref_mem[29'h100]  = 64'hDEADBEEF_CAFEF00D;
    dram_mem[29'h100] = 64'hDEADBEEF_CAFEF00D;
    repeat (3) step();
    @(negedge clk);
    chk_outs_zero("reset_outputs");
    step();
    rst_aL = 1'b1;
    step();

    // icache read, L=3
    dram_lat = 3;
    r0 = n_resp;
    req_i(29'h100);
    wait_resp(r0);
    chk(dvalid_cyc - grant_cyc == 1, "dram_req_latency",
        64'(dvalid_cyc - grant_cyc), 64'd1);
    chk(resp_cyc - grant_cyc == 5, "i_resp_latency",
        64'(resp_cyc - grant_cyc), 64'd5);
    drain();

    // dcache write then read-back of the same block
    req_d(WRITE, 29'h200, 64'h1122334455667788);
    drain();
    req_d(READ, 29'h200, 64'h0);
    drain();

    // Both requesters always valid: starvation bound
    glog.delete();
    icache_req_valid      = 1'b1;
    icache_req_block_addr = 29'h500;
    dcache_req_valid      = 1'b1;
    dcache_req_type       = READ;
    dcache_req_block_addr = 29'h600;
    for (int k = 0; k < 300 && glog.size() < 10; k++) begin
      @(negedge clk);
      ig = icache_req_valid && icache_req_ready;
      dg = dcache_req_valid && dcache_req_ready;
      step();
      if (ig) icache_req_block_addr += 29'd1;
      if (dg) dcache_req_block_addr += 29'd1;
    end
    dcache_req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ok = (i < glog.size()) && (glog[i] == exp_seq[i]);
      chk(ok, "starve_seq", 64'(i), 64'(exp_seq[i]));
    end
    hold_until_granted();
    drain();

    // DRAM backpressure for 6 cycles
    bp_cycles = 6;
    req_d(WRITE, 29'h300, 64'hA1B2C3D4E5F60718);
    drain();
    chk(stall_n == 6, "bp_stall_cycles", 64'(stall_n), 64'd6);
    bp_cycles = 0;
    step();

    // Spurious DRAM completion while idle
    r0 = n_resp;
    spur_cnt++;
    repeat (6) step();
    chk(n_resp == r0, "spurious_ignored", 64'(n_resp), 64'(r0));
    dram_lat = 1;
    req_i(29'h300);
    wait_resp(r0);
    chk(resp_cyc - grant_cyc == 3, "i_resp_latency_l1",
        64'(resp_cyc - grant_cyc), 64'd3);
    drain();

    // Reset while waiting on DRAM
    dram_lat = 10;
    h0 = dram_hs_cnt;
    req_i(29'h140);
    for (int k = 0; k < 50 && dram_hs_cnt == h0; k++) step();
    chk(dram_hs_cnt > h0, "dram_hs_timeout",
        64'(dram_hs_cnt), 64'(h0 + 1));
    rst_aL = 1'b0;
    step();
    @(negedge clk);
    chk_outs_zero("wait_reset_outputs");
    step();
    rst_aL = 1'b1;
    r0 = n_resp;
    repeat (15) step();
    chk(n_resp == r0, "late_resp_ignored", 64'(n_resp), 64'(r0));
    dram_lat = 3;
    req_i(29'h140);
    wait_resp(r0);
    chk(resp_cyc - grant_cyc == 5, "i_resp_after_reset",
        64'(resp_cyc - grant_cyc), 64'd5);
    drain();

    // Randomized traffic
    lat_rand = 1;
    bp_rand  = 1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      ig = icache_req_valid && icache_req_ready;
      dg = dcache_req_valid && dcache_req_ready;
      step();
      if (ig) icache_req_valid = 1'b0;
      if (dg) dcache_req_valid = 1'b0;
      if (!icache_req_valid && $urandom_range(0, 99) < 40) begin
        icache_req_valid      = 1'b1;
        icache_req_block_addr = 29'h400
                              + 29'($urandom_range(0, 15));
      end
      if (!dcache_req_valid && $urandom_range(0, 99) < 40) begin
        dcache_req_valid      = 1'b1;
        dcache_req_type       = req_type_t'($urandom_range(0, 1));
        dcache_req_block_addr = 29'h400
                              + 29'($urandom_range(0, 15));
        dcache_req_block_data = {$urandom, $urandom};
      end
    end
    hold_until_granted();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
